mix_optim_w: RTL

Momentum-SGD optimizer for the mix-layer weight matrix. On an `update` pulse it sweeps every word of the weight, momentum and gradient RAMs and writes back new momentum and weight values. On a `zero_grad` pulse it clears the gradient RAM. It sits downstream of `mix_backward`, consuming the gradients that block accumulates into the grad RAM, and upstream of `mix_ram_w`. `mix_w_transpose` later refreshes `mix_ram_wt` from `mix_ram_w`.

---
 rtl/mix_optim_w_if.sv | 39 +++
 rtl/mix_optim_w.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mix_optim_w_if.sv
// Optimizer <-> RAM / control bus for mix_optim_w.
// master: the optimizer side. slave: the RAMs and the sequencing logic around them.
`timescale 1ns/1ps
interface mix_optim_w_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_N     = 16,
  parameter int N_LEN_W    = 16
);
  localparam int DW = DATA_N * N_LEN_W;

  logic                  update;
  logic                  zero_grad;
  logic                  valid_update;
  logic                  valid_zero_grad;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DW-1:0]         rdata_w;
  logic [DW-1:0]         rdata_v;
  logic [DW-1:0]         rdata_grad;
  logic                  load_w;
  logic                  load_v;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DW-1:0]         wdata_w;
  logic [DW-1:0]         wdata_v;
  logic                  load_grad;
  logic [ADDR_WIDTH-1:0] waddr_grad;
  logic [DW-1:0]         wdata_grad;

  modport master (
    input  update, zero_grad, rdata_w, rdata_v, rdata_grad,
    output valid_update, valid_zero_grad, raddr, load_w, load_v, waddr,
           wdata_w, wdata_v, load_grad, waddr_grad, wdata_grad
  );

  modport slave (
    output update, zero_grad, rdata_w, rdata_v, rdata_grad,
    input  valid_update, valid_zero_grad, raddr, load_w, load_v, waddr,
           wdata_w, wdata_v, load_grad, waddr_grad, wdata_grad
  );
endinterface

// File: rtl/mix_optim_w.sv
// Momentum-SGD optimizer for the mix-layer weights: sweeps w/v/grad RAMs on update,
// clears the grad RAM on zero_grad.
`timescale 1ns/1ps
module mix_optim_w #(
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 384,
  parameter int DATA_N     = 16,
  parameter int N_LEN_W    = 16,
  parameter int MOM_SHIFT  = 3,
  parameter int LR_SHIFT   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mix_optim_w_if.master bus
);
  localparam int DW = DATA_N * N_LEN_W;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic signed [N_LEN_W+1:0] SMAX = {3'b000, {(N_LEN_W-1){1'b1}}};
  localparam logic signed [N_LEN_W+1:0] SMIN = {3'b111, {(N_LEN_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DRAIN, S_ZERO} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_start_upd;
  logic                  w_start_zero;
  logic                  w_issue;
  logic                  w_upd_done;
  logic                  w_zero_done;

  logic [ADDR_WIDTH-1:0] r_raddr;
  logic                  r_rvld;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_load;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DW-1:0]         r_wdata_w;
  logic [DW-1:0]         r_wdata_v;
  logic                  r_load_grad;
  logic [ADDR_WIDTH-1:0] r_waddr_grad;
  logic                  r_valid_update;
  logic                  r_valid_zero;

  logic [DW-1:0]         w_wdata_w;
  logic [DW-1:0]         w_wdata_v;
  logic [2*N_LEN_W-1:0]  w_lane;

  function automatic logic [N_LEN_W-1:0] sat(input logic signed [N_LEN_W+1:0] x);
    if (x > SMAX)      return {1'b0, {(N_LEN_W-1){1'b1}}};
    else if (x < SMIN) return {1'b1, {(N_LEN_W-1){1'b0}}};
    else               return x[N_LEN_W-1:0];
  endfunction

  // Returns {w_new, v_new}; the momentum is saturated before it feeds the weight step.
  function automatic logic [2*N_LEN_W-1:0] lane_step(input logic [N_LEN_W-1:0] w,
                                                     input logic [N_LEN_W-1:0] v,
                                                     input logic [N_LEN_W-1:0] g);
    logic signed [N_LEN_W+1:0] ve;
    logic signed [N_LEN_W+1:0] ge;
    logic signed [N_LEN_W+1:0] we;
    logic signed [N_LEN_W+1:0] acc;
    logic [N_LEN_W-1:0]        vn;
    logic [N_LEN_W-1:0]        wn;
    ve  = {{2{v[N_LEN_W-1]}}, v};
    ge  = {{2{g[N_LEN_W-1]}}, g};
    we  = {{2{w[N_LEN_W-1]}}, w};
    acc = ve - (ve >>> MOM_SHIFT) + ge;
    vn  = sat(acc);
    ve  = {{2{vn[N_LEN_W-1]}}, vn};
    acc = we - (ve >>> LR_SHIFT);
    wn  = sat(acc);
    return {wn, vn};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_start_upd  = 1'b0;
    w_start_zero = 1'b0;
    w_issue      = 1'b0;
    w_upd_done   = 1'b0;
    w_zero_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.update) begin
          w_next      = S_UPDATE;
          w_start_upd = 1'b1;
        end else if (bus.zero_grad) begin
          w_next       = S_ZERO;
          w_start_zero = 1'b1;
        end
      end
      S_UPDATE: begin
        w_issue = 1'b1;
        if (r_raddr == LAST) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_load && (r_waddr == LAST)) begin
          w_upd_done = 1'b1;
          w_next     = S_IDLE;
        end
      end
      S_ZERO: begin
        if (r_waddr_grad == LAST) begin
          w_zero_done = 1'b1;
          w_next      = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_wdata_w = '0;
    w_wdata_v = '0;
    w_lane    = '0;
    for (int unsigned i = 0; i < DATA_N; i++) begin
      w_lane = lane_step(bus.rdata_w[i*N_LEN_W +: N_LEN_W],
                         bus.rdata_v[i*N_LEN_W +: N_LEN_W],
                         bus.rdata_grad[i*N_LEN_W +: N_LEN_W]);
      w_wdata_w[i*N_LEN_W +: N_LEN_W] = w_lane[2*N_LEN_W-1:N_LEN_W];
      w_wdata_v[i*N_LEN_W +: N_LEN_W] = w_lane[N_LEN_W-1:0];
    end
  end

  // issue (raddr) -> read (rdata + compute) -> registered write; writes trail reads by 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raddr        <= '0;
      r_rvld         <= 1'b0;
      r_rd_addr      <= '0;
      r_load         <= 1'b0;
      r_waddr        <= '0;
      r_wdata_w      <= '0;
      r_wdata_v      <= '0;
      r_load_grad    <= 1'b0;
      r_waddr_grad   <= '0;
      r_valid_update <= 1'b0;
      r_valid_zero   <= 1'b0;
    end else begin
      r_valid_update <= w_upd_done;
      r_valid_zero   <= w_zero_done;

      if (w_start_upd)                    r_raddr <= '0;
      else if (w_issue && r_raddr != LAST) r_raddr <= r_raddr + 1'b1;

      r_rvld    <= w_issue;
      r_rd_addr <= r_raddr;
      r_load    <= r_rvld;
      if (r_rvld) begin
        r_waddr   <= r_rd_addr;
        r_wdata_w <= w_wdata_w;
        r_wdata_v <= w_wdata_v;
      end

      if (w_start_zero) begin
        r_load_grad  <= 1'b1;
        r_waddr_grad <= '0;
      end else if (w_zero_done) begin
        r_load_grad  <= 1'b0;
      end else if (r_load_grad) begin
        r_waddr_grad <= r_waddr_grad + 1'b1;
      end
    end
  end

  assign bus.raddr           = r_raddr;
  assign bus.load_w          = r_load;
  assign bus.load_v          = r_load;
  assign bus.waddr           = r_waddr;
  assign bus.wdata_w         = r_wdata_w;
  assign bus.wdata_v         = r_wdata_v;
  assign bus.load_grad       = r_load_grad;
  assign bus.waddr_grad      = r_waddr_grad;
  assign bus.wdata_grad      = '0;
  assign bus.valid_update    = r_valid_update;
  assign bus.valid_zero_grad = r_valid_zero;
endmodule
